// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the data-RAM arbiter between the CPU data port and a DMA master.
package ram_arb_pkg;

  typedef enum logic {
    StPriM1   = 1'b0,
    StForceM0 = 1'b1
  } arb_state_e;

  // Width that can hold the value max_burst itself.
  function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
    return (max_burst < 2) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Single-port data RAM arbiter: DMA (M1) has fixed priority, with an anti-starvation
// window that forces one CPU (M0) grant after MAX_BURST back-to-back M1 grants.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            M0_RD,
  input  logic            M0_WR,
  input  logic [DW/8-1:0] M0_BE,
  input  logic [AW-1:0]   M0_ADDR,
  input  logic [DW-1:0]   M0_DATAO,
  output logic [DW-1:0]   M0_DATAI,
  output logic            M0_HLT,
  input  logic            M1_REQ,
  input  logic            M1_WR,
  input  logic [DW/8-1:0] M1_BE,
  input  logic [AW-1:0]   M1_ADDR,
  input  logic [DW-1:0]   M1_DATAO,
  output logic            M1_ACK,
  output logic [DW-1:0]   M1_DATAI,
  output logic            M1_VLD,
  output logic [AW-1:0]   RAM_A,
  output logic [DW-1:0]   RAM_D,
  output logic            RAM_WE,
  output logic [DW/8-1:0] RAM_BE,
  input  logic [DW-1:0]   RAM_Q
);

  localparam int unsigned BW = burst_cnt_w(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d, burst_cnt_inc;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_own_q, rd_own_d;
  logic          req0, req1, gnt0, gnt1;

  always_comb begin
    req0 = M0_RD | M0_WR;
    req1 = M1_REQ;
    if (state_q == StForceM0) begin
      gnt0 = req0;
      gnt1 = req1 & ~req0;
    end else begin
      gnt1 = req1;
      gnt0 = req0 & ~req1;
    end
  end

  // FORCE_M0 lasts exactly one cycle, so the default next state is PRI_M1.
  always_comb begin
    state_d       = StPriM1;
    burst_cnt_d   = burst_cnt_q;
    burst_cnt_inc = burst_cnt_q + BW'(1);
    if (gnt0 || !req0) begin
      burst_cnt_d = '0;
    end else if (gnt1) begin
      if (burst_cnt_inc == BW'(MAX_BURST)) begin
        state_d     = StForceM0;
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = burst_cnt_inc;
      end
    end
  end

  // A simultaneous M0 read+write is treated as a write: no read return is scheduled.
  always_comb begin
    rd_pend_d = (gnt0 & M0_RD & ~M0_WR) | (gnt1 & ~M1_WR);
    rd_own_d  = gnt1;
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q     <= StPriM1;
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_own_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_own_q    <= rd_own_d;
    end
  end

  always_comb begin
    RAM_A    = gnt1 ? M1_ADDR  : M0_ADDR;
    RAM_D    = gnt1 ? M1_DATAO : M0_DATAO;
    RAM_BE   = gnt1 ? M1_BE    : M0_BE;
    RAM_WE   = (gnt0 & M0_WR) | (gnt1 & M1_WR);
    M0_HLT   = req0 & ~gnt0;
    M1_ACK   = gnt1;
    M1_VLD   = rd_pend_q & rd_own_q;
    M1_DATAI = RAM_Q;
    M0_DATAI = RAM_Q;
  end

endmodule
